// File: rtl/acumulador_trama.sv
// Frame accumulator: sums TAPS signed 2N-bit samples in a guard-extended register, then emits one result with a strobe.
// Define ACUMULADOR_TRAMA_SAT_EN for a saturated result and sticky overflow; without it the result wraps and overflow reads 0.
module acumulador_trama #(
    parameter int N     = 25,
    parameter int TAPS  = 8,
    parameter int GUARD = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [2*N-1:0] In,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           clear,
    output logic [2*N-1:0] Acumulado,
    output logic           out_valid,
    output logic           overflow
);

    localparam int W  = 2 * N;
    localparam int AW = W + GUARD;
    localparam int CW = $clog2(TAPS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(TAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [W-1:0]          res_q, res_d;
    logic                  out_valid_q, out_valid_d;
    logic [W-1:0]          res_fmt;
    logic signed [AW-1:0]  in_ext;
    logic                  accept;
    logic [1:0]            rst_sync_q;
    logic                  rst_n;

    // Reset asserts immediately but is released only after two clean edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    assign in_ready = (state_q != DONE);
    assign accept   = in_valid && in_ready;
    assign in_ext   = {{GUARD{In[W-1]}}, In};

`ifdef ACUMULADOR_TRAMA_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX = {{(GUARD + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(GUARD + 1){1'b1}}, {(W - 1){1'b0}}};

    logic sat_hit;
    logic ovf_q, ovf_d;

    always_comb begin
        sat_hit = 1'b0;
        res_fmt = acc_q[W-1:0];
        if (acc_q > SAT_MAX) begin
            sat_hit = 1'b1;
            res_fmt = SAT_MAX[W-1:0];
        end else if (acc_q < SAT_MIN) begin
            sat_hit = 1'b1;
            res_fmt = SAT_MIN[W-1:0];
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (clear) begin
            ovf_d = 1'b0;
        end else if (state_q == DONE && sat_hit) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign res_fmt  = acc_q[W-1:0];
    assign overflow = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        out_valid_d = 1'b0;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d   = in_ext;
                        cnt_d   = CW'(1);
                        state_d = (TAPS == 1) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc_d = acc_q + in_ext;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == LAST_CNT) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    res_d       = res_fmt;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                    acc_d       = '0;
                    cnt_d       = '0;
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign Acumulado = res_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_acumulador_trama.sv
// Self-checking bench for acumulador_trama (N=4, TAPS=4, GUARD=2): directed plan plus random traffic against a queue-based model.
module tb_acumulador_trama;

    localparam int N     = 4;
    localparam int TAPS  = 4;
    localparam int GUARD = 2;
    localparam int W     = 2 * N;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] In;
    logic         in_valid;
    logic         in_ready;
    logic         clear;
    logic [W-1:0] Acumulado;
    logic         out_valid;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: samples of the current frame, pending-result flag, visible outputs.
    int           m_q[$];
    bit           m_done;
    logic [W-1:0] m_res;
    bit           m_ovalid;
    bit           m_ovf;

    always #5 clk = ~clk;

    acumulador_trama #(
        .N    (N),
        .TAPS (TAPS),
        .GUARD(GUARD)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .In       (In),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .clear    (clear),
        .Acumulado(Acumulado),
        .out_valid(out_valid),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] fmt(input int s, output bit hit);
        hit = 1'b0;
`ifdef ACUMULADOR_TRAMA_SAT_EN
        if (s > 127) begin
            hit = 1'b1;
            return 8'h7F;
        end
        if (s < -128) begin
            hit = 1'b1;
            return 8'h80;
        end
`endif
        return W'(s);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_done   = 1'b0;
        m_res    = '0;
        m_ovalid = 1'b0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [W-1:0] d, input logic c);
        int sum;
        bit hit;
        if (c) begin
            m_q.delete();
            m_done   = 1'b0;
            m_ovalid = 1'b0;
            m_ovf    = 1'b0;
        end else if (m_done) begin
            sum = 0;
            foreach (m_q[i]) sum += m_q[i];
            m_res    = fmt(sum, hit);
            m_ovalid = 1'b1;
            m_ovf    = m_ovf | hit;
            m_done   = 1'b0;
            m_q.delete();
        end else begin
            m_ovalid = 1'b0;
            if (v) begin
                m_q.push_back(int'($signed(d)));
                if (m_q.size() == TAPS) m_done = 1'b1;
            end
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic c);
        in_valid = v;
        In       = d;
        clear    = c;
        @(posedge clk);
        model_edge(v, d, c);
        #1;
        check("acumulado", Acumulado, m_res);
        check("out_valid", out_valid, m_ovalid);
        check("overflow", overflow, m_ovf);
        check("in_ready", in_ready, !m_done);
    endtask

    task automatic send4(input logic [W-1:0] d);
        for (int i = 0; i < TAPS; i++) step(1'b1, d, 1'b0);
    endtask

    initial begin
        logic [W-1:0] vals[4];
        bit sat_en;
`ifdef ACUMULADOR_TRAMA_SAT_EN
        sat_en = 1'b1;
`else
        sat_en = 1'b0;
`endif
        reset_n  = 1'b0;
        in_valid = 1'b0;
        In       = '0;
        clear    = 1'b0;
        model_reset();
        #12;
        check("rst_acumulado", Acumulado, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);

        // Basic frame: 10+20+30+40, result two edges after the last accept.
        vals = '{8'd10, 8'd20, 8'd30, 8'd40};
        for (int i = 0; i < 4; i++) step(1'b1, vals[i], 1'b0);
        check("basic_no_strobe_yet", out_valid, 0);
        step(1'b0, '0, 1'b0);
        check("basic_sum", Acumulado, 8'h64);
        check("basic_strobe", out_valid, 1);
        check("basic_ovf", overflow, 0);
        step(1'b0, '0, 1'b0);

        // Positive overflow, then an in-range frame to show overflow is sticky.
        send4(8'd100);
        step(1'b0, '0, 1'b0);
        check("pos_ovf_sum", Acumulado, sat_en ? 8'h7F : 8'h90);
        check("pos_ovf_flag", overflow, sat_en ? 1 : 0);
        for (int i = 0; i < 4; i++) step(1'b1, vals[i], 1'b0);
        step(1'b0, '0, 1'b0);
        check("ovf_sticky", overflow, sat_en ? 1 : 0);

        // Negative overflow.
        send4(W'(-100));
        step(1'b0, '0, 1'b0);
        check("neg_ovf_sum", Acumulado, sat_en ? 8'h80 : 8'h70);

        // Gapped frame; a sample offered during DONE must not be consumed.
        step(1'b1, 8'd5, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'd99, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'd5, 1'b0);
        check("gap_done_not_ready", in_ready, 0);
        step(1'b1, 8'd9, 1'b0);
        check("gap_sum", Acumulado, 8'd20);
        // Next frame starts in the strobe cycle; a consumed 9 would give 15.
        send4(8'd2);
        step(1'b0, '0, 1'b0);
        check("b2b_sum", Acumulado, 8'd8);

        // Set overflow again (SAT build), then abort a frame with clear.
        send4(8'd100);
        step(1'b0, '0, 1'b0);
        step(1'b1, 8'd3, 1'b0);
        step(1'b1, 8'd3, 1'b0);
        step(1'b1, 8'd7, 1'b1);
        check("clear_ovf", overflow, 0);
        check("clear_hold", Acumulado, sat_en ? 8'h7F : 8'h90);
        send4(8'd1);
        step(1'b0, '0, 1'b0);
        check("clear_sum", Acumulado, 8'd4);

        // Clear during DONE cancels the result.
        send4(8'd6);
        step(1'b0, '0, 1'b1);
        check("clr_done_no_strobe", out_valid, 0);
        check("clr_done_hold", Acumulado, 8'd4);

        // Asynchronous reset mid-frame.
        step(1'b1, 8'd2, 1'b0);
        step(1'b1, 8'd2, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("arst_acumulado", Acumulado, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_overflow", overflow, 0);
        check("arst_in_ready", in_ready, 1);
        #3 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        send4(8'd2);
        step(1'b0, '0, 1'b0);
        check("arst_sum", Acumulado, 8'd8);

        // Random traffic with gaps and occasional clears.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, W'($urandom_range(0, 255)), $urandom_range(0, 49) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/acumulador_trama.md
# acumulador_trama

Frame accumulator for the filter datapath: sums exactly TAPS signed 2N-bit products, accepted over a valid/ready handshake, in a guard-extended internal register. It then presents the saturated (or wrapped) sum as one registered result with a one-cycle `out_valid` strobe. It sits between the multiplier stage and the output formatter. It replaces the plain hold register: it adds frame counting, a handshake, guard bits, synchronous clear and overflow reporting.

## Interface
- `N`, 25, half-width of data; data paths are 2N bits, two's complement.
- `TAPS`, 8, samples summed per frame; legal range 1..2^GUARD.
- `GUARD`, 4, extra internal accumulator bits; internal width is 2N+GUARD.

- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `In`  in  2N  signed sample/product.
- `in_valid`  in  1  `In` is valid this cycle.
- `in_ready`  out  1  block accepts `In`; a sample is taken when `in_valid && in_ready` at the rising edge.
- `clear`  in  1  synchronous frame abort.
- `Acumulado`  out  2N  registered frame result; holds between frames.
- `out_valid`  out  1  one-cycle strobe: `Acumulado` is new.
- `overflow`  out  1  sticky: some frame result saturated.

## Operation
- State machine: IDLE, ACC, DONE. `in_ready` = (state != DONE), combinational from state.
- **IDLE**
  - On accept: `acc` <= sign-extend(`In`), `cnt` <= 1.
  - Next state is ACC, or DONE if TAPS==1.
- **ACC**
  - On accept: `acc` <= `acc` + sign-extend(`In`), `cnt`++.
  - After the TAPS-th accepted sample, go to DONE.
  - Cycles with no accept hold all state; idle gaps inside a frame are allowed.
- **DONE** (exactly one cycle; `in_ready`=0)
  - At the edge: `Acumulado` <= fmt(`acc`), `out_valid` <= 1, `overflow` |= sat_hit.
  - Next state is IDLE; `acc` and `cnt` are cleared.
- `out_valid` is registered and deasserts after one cycle unless another DONE follows.
- **`clear`**
  - Forces state to IDLE and `acc`, `cnt` to 0.
  - Clears `overflow`.
  - `Acumulado` holds its value; `out_valid` <= 0.
  - `clear` has priority over `in_valid`; a sample offered in the same cycle is dropped.
  - `clear` during DONE cancels the result: `Acumulado` is not updated and no strobe is issued.
- Arithmetic: the internal sum cannot overflow, because TAPS <= 2^GUARD. fmt() is defined under Configuration.
- `cnt` width is clog2(TAPS+1).

## Timing
- Reset (asynchronous on assertion, released synchronously by the design):
  - state IDLE, `acc`=0, `cnt`=0.
  - `Acumulado`=0, `out_valid`=0, `overflow`=0, `in_ready`=1.
- Latency: the last sample is accepted at edge k; DONE occupies the cycle after k; `out_valid`=1 and the new `Acumulado` are visible after edge k+1.
- Throughput: one frame per TAPS+1 cycles with back-to-back valid input. The next frame's first sample is accepted in the cycle in which `out_valid` is high.
- Reset mid-frame discards the partial sum immediately.

## Configuration
- `ACUMULADOR_TRAMA_SAT_EN` defined: fmt() saturates `acc` to [-2^(2N-1), 2^(2N-1)-1]. sat_hit is set whenever clipping occurs.
- Not defined: fmt() takes the low 2N bits (wrap-around), and `overflow` is tied to 0.

## Test plan
All scenarios use N=4, TAPS=4, GUARD=2.
- Reset, then `In` = 10, 20, 30, 40 back-to-back -> `Acumulado`=100 (0x64), `out_valid` one cycle, 2 edges after the 4th accept; `overflow`=0.
- 100 ×4 -> SAT_EN: 127 (0x7F), `overflow`=1 and stays 1. No SAT_EN: 0x90, `overflow`=0.
- -100 ×4 -> SAT_EN: 0x80; no SAT_EN: 0x70.
- Gapped input: 5, idle 3 cycles, 5, 5, 5 -> 20; `in_ready` low only in the DONE cycle. An `in_valid` offered during DONE is not consumed.
- Two samples, then `clear` together with `in_valid`(7), then 1, 1, 1, 1 -> result 4; `Acumulado` keeps its previous value until then; `overflow` cleared.
- `reset_n` pulsed low mid-frame (asynchronously, between edges) -> all outputs 0 at once. The next 4 samples of 2 give 8.
